acumulador_saida: RTL

ACUMULADOR_SAIDA -- requirements
Module: acumulador_saida

---
 rtl/acumulador_saida.sv | 128 ++++++++++++
 1 files changed

// File: rtl/acumulador_saida.sv
`default_nettype none
// ============================================================================
// Module   : acumulador_saida
// Purpose  : Output accumulator for the adder stage. Sums a programmed number
//            of 8-bit samples (signed or unsigned) into a saturating 10-bit
//            total, then holds the total until the downstream consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module acumulador_saida (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic [3:0] quantidade,
  input  logic [1:0] codigo,
  input  logic [7:0] entrada,
  input  logic       entrada_valida,
  output logic       entrada_pronta,
  output logic [9:0] acumulado,
  output logic       saida_valida,
  input  logic       saida_pronta,
  output logic       overflow,
  output logic [4:0] contagem
);

  // Clamp limits of the 10-bit result
  localparam logic [9:0] C_MAX_SIGNED   = 10'h1FF;
  localparam logic [9:0] C_MIN_SIGNED   = 10'h200;
  localparam logic [9:0] C_MAX_UNSIGNED = 10'h3FF;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ACUMULA   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  estado_t    estado_q;
  logic [4:0] quant_q;       // latched run length, 1..16
  logic       signed_q;      // latched mode: 1 = signed
  logic [9:0] acc_q;
  logic       ovf_q;
  logic [4:0] cnt_q;
  logic       saida_valida_q;

  logic [10:0] ext_in;
  logic [10:0] ext_acc;
  logic [10:0] soma;
  logic [9:0]  acc_d;
  logic        clamp_d;
  logic [4:0]  cnt_d;

  // Extend sample and running total to 11 bits, add exactly, then saturate
  always_comb begin
    ext_in  = signed_q ? {{3{entrada[7]}}, entrada} : {3'b000, entrada};
    ext_acc = signed_q ? {acc_q[9], acc_q}          : {1'b0, acc_q};
    soma    = ext_in + ext_acc;
    acc_d   = soma[9:0];
    clamp_d = 1'b0;
    if (signed_q) begin
      // Bits 10 and 9 disagree only when the true sum leaves -512..511
      if (!soma[10] && soma[9]) begin
        acc_d   = C_MAX_SIGNED;
        clamp_d = 1'b1;
      end else if (soma[10] && !soma[9]) begin
        acc_d   = C_MIN_SIGNED;
        clamp_d = 1'b1;
      end
    end else if (soma[10]) begin
      acc_d   = C_MAX_UNSIGNED;
      clamp_d = 1'b1;
    end
    cnt_d = cnt_q + 5'd1;
  end

  // Control FSM together with the accumulator datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= OCIOSO;
      quant_q        <= 5'd16;
      signed_q       <= 1'b0;
      acc_q          <= 10'd0;
      ovf_q          <= 1'b0;
      cnt_q          <= 5'd0;
      saida_valida_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (inicio) begin
            quant_q  <= (quantidade == 4'd0) ? 5'd16 : {1'b0, quantidade};
            signed_q <= (codigo == 2'b00);
            acc_q    <= 10'd0;
            ovf_q    <= 1'b0;
            cnt_q    <= 5'd0;
            estado_q <= ACUMULA;
          end
        end
        ACUMULA: begin
          if (entrada_valida) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | clamp_d;
            cnt_q <= cnt_d;
            if (cnt_d == quant_q) begin
              estado_q       <= RESULTADO;
              saida_valida_q <= 1'b1;
            end
          end
        end
        RESULTADO: begin
          if (saida_pronta) begin
            estado_q       <= OCIOSO;
            saida_valida_q <= 1'b0;
          end
        end
        default: begin
          estado_q       <= OCIOSO;
          saida_valida_q <= 1'b0;
        end
      endcase
    end
  end

  assign entrada_pronta = (estado_q == ACUMULA);
  assign saida_valida   = saida_valida_q;
  assign acumulado      = acc_q;
  assign overflow       = ovf_q;
  assign contagem       = cnt_q;

endmodule
`default_nettype wire
